// File: rtl/usb_tx_pkt_ctrl.sv
// usb_tx_pkt_ctrl
// USB full-speed transmit packet controller. It feeds the parallel-to-serial
// shifter with one byte at a time, in this order: SYNC, PID, payload, CRC16.
// It then holds the encoder in EOP for the SE0 bit times plus one J bit time.
// Supported packets are DATA0, DATA1, ACK, NAK and STALL.
// Optional feature: define TX_CRC16_EN to compute the CRC16 internally over
// the payload. Without it, the CRC bytes are taken from crc_in.
module usb_tx_pkt_ctrl #(
  parameter int MAX_DATA_BYTES = 64,
  parameter int SIZE_W         = 7,
  parameter int EOP_SE0_BITS   = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        tx_packet,
  input  logic [SIZE_W-1:0] tx_packet_data_size,
  input  logic [7:0]        tx_packet_data,
  output logic              get_tx_packet_data,
  input  logic              byte_complete,
  input  logic              bit_tick,
  input  logic [15:0]       crc_in,
  output logic              load_enable,
  output logic [7:0]        data_pts,
  output logic [2:0]        tx_state,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_trunc
);

  // Controller states
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SYNC   = 4'd1;
  localparam logic [3:0] ST_PID    = 4'd2;
  localparam logic [3:0] ST_FETCH  = 4'd3;
  localparam logic [3:0] ST_DATA   = 4'd4;
  localparam logic [3:0] ST_CRC_LO = 4'd5;
  localparam logic [3:0] ST_CRC_HI = 4'd6;
  localparam logic [3:0] ST_EOP    = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;

  // Encoder modes presented on tx_state
  localparam logic [2:0] ENC_IDLE = 3'd0;
  localparam logic [2:0] ENC_SYNC = 3'd1;
  localparam logic [2:0] ENC_PID  = 3'd2;
  localparam logic [2:0] ENC_DATA = 3'd3;
  localparam logic [2:0] ENC_CRC  = 3'd4;
  localparam logic [2:0] ENC_EOP  = 3'd5;

  // Packet type codes on tx_packet
  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;
  localparam logic [2:0] PKT_STALL = 3'd5;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAX_DATA_BYTES);

  // The EOP counter must count up to EOP_SE0_BITS, which is the index of
  // the final J bit tick.
  localparam int EOP_W = $clog2(EOP_SE0_BITS + 2);
  localparam logic [EOP_W-1:0] EOP_LAST = EOP_W'(EOP_SE0_BITS);

  logic [3:0]        state;
  logic [2:0]        pkt_type;
  logic [SIZE_W-1:0] size_lat;
  logic [SIZE_W-1:0] byte_cnt;
  logic [EOP_W-1:0]  eop_cnt;
  logic [15:0]       crc_reg;
  logic              data_pending;

  logic              start_req;
  logic              size_over;
  logic [SIZE_W-1:0] size_clipped;
  logic              bc_ok;
  logic              is_handshake;
  logic              pid_to_crc;
  logic              data_to_crc;
  logic [7:0]        crc_lo_byte;
  logic [7:0]        crc_hi_byte;

  // PID byte is the 4-bit PID in the low nibble, with its complement above it
  function automatic logic [7:0] pid_byte(input logic [2:0] t);
    logic [7:0] p;
    case (t)
      PKT_DATA0: p = 8'hC3;
      PKT_DATA1: p = 8'h4B;
      PKT_ACK:   p = 8'hD2;
      PKT_NAK:   p = 8'h5A;
      PKT_STALL: p = 8'h1E;
      default:   p = 8'h00;
    endcase
    return p;
  endfunction

`ifdef TX_CRC16_EN
  // One byte of reflected CRC16 (poly 8005, reflected form A001), LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction
`endif

  assign start_req    = (tx_packet != 3'd0) && (tx_packet <= PKT_STALL);
  assign size_over    = tx_packet_data_size > MAX_SIZE;
  assign size_clipped = size_over ? MAX_SIZE : tx_packet_data_size;

  // A byte_complete pulse in the same cycle as a load belongs to the byte
  // that is already being replaced, so it is not acted on.
  assign bc_ok        = byte_complete && !load_enable;
  assign is_handshake = pkt_type >= PKT_ACK;

  assign pid_to_crc  = (state == ST_PID) && bc_ok && !is_handshake &&
                       (size_lat == '0);
  assign data_to_crc = (state == ST_DATA) && !data_pending && bc_ok &&
                       !(byte_cnt < size_lat);

`ifdef TX_CRC16_EN
  logic unused_crc_in;
  assign unused_crc_in = ^crc_in;
  assign crc_lo_byte   = ~crc_reg[7:0];
  assign crc_hi_byte   = ~crc_reg[15:8];
`else
  assign crc_lo_byte   = crc_in[7:0];
  assign crc_hi_byte   = crc_reg[15:8];
`endif

  // CRC register: cleared at packet start. With internal CRC it accumulates each payload byte; otherwise it captures crc_in on entry to CRC_LO
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_reg <= 16'hFFFF;
    end else if ((state == ST_IDLE) && start_req) begin
      crc_reg <= 16'hFFFF;
`ifdef TX_CRC16_EN
    end else if ((state == ST_DATA) && data_pending) begin
      crc_reg <= crc16_byte(crc_reg, tx_packet_data);
`else
    end else if (pid_to_crc || data_to_crc) begin
      crc_reg <= crc_in;
`endif
    end
  end

  // Packet sequencer: walks the states and drives every registered output
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= ST_IDLE;
      pkt_type           <= 3'd0;
      size_lat           <= '0;
      byte_cnt           <= '0;
      eop_cnt            <= '0;
      data_pending       <= 1'b0;
      load_enable        <= 1'b0;
      data_pts           <= 8'h00;
      get_tx_packet_data <= 1'b0;
      tx_state           <= ENC_IDLE;
      tx_busy            <= 1'b0;
      tx_done            <= 1'b0;
      tx_trunc           <= 1'b0;
    end else begin
      load_enable        <= 1'b0;
      get_tx_packet_data <= 1'b0;
      tx_done            <= 1'b0;
      tx_trunc           <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state        <= ST_SYNC;
            pkt_type     <= tx_packet;
            size_lat     <= size_clipped;
            byte_cnt     <= '0;
            eop_cnt      <= '0;
            data_pending <= 1'b0;
            tx_busy      <= 1'b1;
            tx_trunc     <= size_over;
            load_enable  <= 1'b1;
            data_pts     <= SYNC_BYTE;
            tx_state     <= ENC_SYNC;
          end
        end

        ST_SYNC: begin
          if (bc_ok) begin
            load_enable <= 1'b1;
            data_pts    <= pid_byte(pkt_type);
            state       <= ST_PID;
            tx_state    <= ENC_PID;
          end
        end

        ST_PID: begin
          if (bc_ok) begin
            if (is_handshake) begin
              state    <= ST_EOP;
              tx_state <= ENC_EOP;
              eop_cnt  <= '0;
            end else if (pid_to_crc) begin
              state       <= ST_CRC_LO;
              tx_state    <= ENC_CRC;
              load_enable <= 1'b1;
              data_pts    <= crc_lo_byte;
            end else begin
              state              <= ST_FETCH;
              tx_state           <= ENC_DATA;
              get_tx_packet_data <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          // The buffer answers the request one clock later, so DATA loads
          // the byte on its first cycle.
          state        <= ST_DATA;
          byte_cnt     <= byte_cnt + 1'b1;
          data_pending <= 1'b1;
        end

        ST_DATA: begin
          if (data_pending) begin
            data_pending <= 1'b0;
            load_enable  <= 1'b1;
            data_pts     <= tx_packet_data;
          end else if (bc_ok) begin
            if (data_to_crc) begin
              state       <= ST_CRC_LO;
              tx_state    <= ENC_CRC;
              load_enable <= 1'b1;
              data_pts    <= crc_lo_byte;
            end else begin
              state              <= ST_FETCH;
              get_tx_packet_data <= 1'b1;
            end
          end
        end

        ST_CRC_LO: begin
          if (bc_ok) begin
            load_enable <= 1'b1;
            data_pts    <= crc_hi_byte;
            state       <= ST_CRC_HI;
          end
        end

        ST_CRC_HI: begin
          if (bc_ok) begin
            state    <= ST_EOP;
            tx_state <= ENC_EOP;
            eop_cnt  <= '0;
          end
        end

        ST_EOP: begin
          if (bit_tick) begin
            if (eop_cnt == EOP_LAST) begin
              state    <= ST_DONE;
              tx_state <= ENC_IDLE;
              tx_done  <= 1'b1;
            end else begin
              eop_cnt <= eop_cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          tx_busy <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          tx_state <= ENC_IDLE;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// tb_usb_tx_pkt_ctrl
// Scoreboard bench for usb_tx_pkt_ctrl. For each packet issued, the driver
// pushes the expected byte loads and the expected fetch count. A monitor
// compares these against what the DUT presents. Small behavioural models
// stand in for the shifter, the bit timer and the TX buffer.
// The CRC expectation follows TX_CRC16_EN, when that macro is defined.
module tb_usb_tx_pkt_ctrl;

  localparam int MAX_DATA_BYTES = 64;
  localparam int SIZE_W         = 7;
  localparam int EOP_SE0_BITS   = 2;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [2:0]        tx_packet;
  logic [SIZE_W-1:0] tx_packet_data_size;
  logic [7:0]        tx_packet_data;
  logic              get_tx_packet_data;
  logic              byte_complete;
  logic              bit_tick;
  logic [15:0]       crc_in;
  logic              load_enable;
  logic [7:0]        data_pts;
  logic [2:0]        tx_state;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_trunc;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] enc;
    logic       trunc;
  } exp_load_t;

  exp_load_t  exp_loads[$];
  int         exp_gets[$];
  logic [7:0] pay_q[$];
  logic [7:0] stim_bytes[$];

  int   total = 0;
  int   bad   = 0;
  int   gets_seen = 0;
  int   eop_ticks = 0;
  logic force_bc = 1'b0;

  logic [3:0] pid_codes [0:7] = '{4'h0, 4'h3, 4'hB, 4'h2, 4'hA, 4'hE, 4'h0, 4'h0};

  usb_tx_pkt_ctrl #(
    .MAX_DATA_BYTES(MAX_DATA_BYTES),
    .SIZE_W(SIZE_W),
    .EOP_SE0_BITS(EOP_SE0_BITS)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .tx_packet(tx_packet),
    .tx_packet_data_size(tx_packet_data_size),
    .tx_packet_data(tx_packet_data),
    .get_tx_packet_data(get_tx_packet_data),
    .byte_complete(byte_complete),
    .bit_tick(bit_tick),
    .crc_in(crc_in),
    .load_enable(load_enable),
    .data_pts(data_pts),
    .tx_state(tx_state),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_trunc(tx_trunc)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    total++;
    bad++;
    $display("[TB] FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Shifter model: a byte takes 8 clocks after its load, then byte_complete pulses
  initial begin : shifter
    int cnt;
    cnt = 0;
    byte_complete = 1'b0;
    forever begin
      @(negedge clk);
      byte_complete = force_bc;
      if (!n_rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) byte_complete = 1'b1;
        end
        if (load_enable) cnt = 8;
      end
    end
  end

  // Bit timer model: free-running tick every 4 clocks; counts the ticks delivered during EOP
  initial begin : bit_timer
    int k;
    k = 0;
    bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      bit_tick = (k % 4 == 3);
      k++;
      if (bit_tick && n_rst && tx_state == 3'd5) eop_ticks++;
    end
  end

  // TX buffer model: the byte appears the cycle after a request; garbage otherwise
  initial begin : buffer
    logic get_prev;
    get_prev = 1'b0;
    tx_packet_data = 8'h00;
    forever begin
      @(negedge clk);
      if (get_prev) tx_packet_data = (pay_q.size() > 0) ? pay_q.pop_front() : 8'hEE;
      else          tx_packet_data = 8'($urandom);
      get_prev = get_tx_packet_data && n_rst;
    end
  end

  // Monitor: pops expectations on every load and on every tx_done
  initial begin : monitor
    exp_load_t e;
    int g;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        gets_seen = 0;
      end else begin
        if (get_tx_packet_data) gets_seen++;
        if (tx_state != 3'd0) check_output("busy_when_active", 32'(tx_busy), 32'd1);
        if (load_enable) begin
          if (exp_loads.size() == 0) begin
            fail_event("load_unexpected", $sformatf("got load %0h expected none", data_pts));
          end else begin
            e = exp_loads.pop_front();
            check_output("load_data", 32'(data_pts), 32'(e.data));
            check_output("load_state", 32'(tx_state), 32'(e.enc));
            if (e.enc == 3'd1) check_output("trunc_at_start", 32'(tx_trunc), 32'(e.trunc));
          end
        end else if (tx_trunc) begin
          fail_event("trunc_stray", "got tx_trunc expected 0 outside start");
        end
        if (tx_done) begin
          if (exp_gets.size() == 0) begin
            fail_event("done_unexpected", "got tx_done expected none");
          end else begin
            g = exp_gets.pop_front();
            check_output("fetch_count", 32'(gets_seen), 32'(g));
            check_output("eop_ticks", 32'(eop_ticks), 32'(EOP_SE0_BITS + 1));
            check_output("loads_left", 32'(exp_loads.size()), 32'd0);
            check_output("busy_at_done", 32'(tx_busy), 32'd1);
            check_output("state_at_done", 32'(tx_state), 32'd0);
          end
          gets_seen = 0;
          eop_ticks = 0;
        end
      end
    end
  end

  // Reference model: expected byte stream, derived from the packet rules
  task automatic apply_stimulus(input logic [2:0] pkt, input int size, input logic [15:0] ext_crc);
    int         n;
    logic       is_data;
    logic [15:0] crc;
    logic [7:0] pb;
    logic       fb;
    logic [3:0] pid4;
    exp_load_t  e;
    is_data = (pkt == 3'd1) || (pkt == 3'd2);
    n = 0;
    if (is_data) n = (size > MAX_DATA_BYTES) ? MAX_DATA_BYTES : size;
    while (stim_bytes.size() < n) stim_bytes.push_back(8'($urandom));
    e.data = 8'h80; e.enc = 3'd1; e.trunc = (size > MAX_DATA_BYTES);
    exp_loads.push_back(e);
    pid4 = pid_codes[pkt];
    e.data = {~pid4, pid4}; e.enc = 3'd2; e.trunc = 1'b0;
    exp_loads.push_back(e);
    crc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      pb = stim_bytes[i];
      pay_q.push_back(pb);
      e.data = pb; e.enc = 3'd3;
      exp_loads.push_back(e);
      for (int b = 0; b < 8; b++) begin
        fb  = pb[b] ^ crc[0];
        crc = crc >> 1;
        if (fb) crc = crc ^ 16'hA001;
      end
    end
    if (is_data) begin
`ifdef TX_CRC16_EN
      crc = ~crc;
`else
      crc = ext_crc;
`endif
      e.data = crc[7:0];  e.enc = 3'd4;
      exp_loads.push_back(e);
      e.data = crc[15:8];
      exp_loads.push_back(e);
    end
    exp_gets.push_back(n);
    stim_bytes.delete();
    tx_packet           = pkt;
    tx_packet_data_size = SIZE_W'(size);
    crc_in              = ext_crc;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tx_packet = 3'd0;
    exp_loads.delete();
    exp_gets.delete();
    pay_q.delete();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (tx_done) seen = 1'b1;
    end
    if (seen) begin
      tx_packet = 3'd0;
    end else begin
      fail_event(name, "got no tx_done expected tx_done within 3000 cycles");
      do_reset();
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Driver: directed cases first, then randomized packets
  initial begin : driver
    int   data_seen;
    logic hit;
    int   sz;
    logic [2:0] t;
    n_rst = 1'b0;
    tx_packet = 3'd0;
    tx_packet_data_size = '0;
    crc_in = 16'h0000;
    repeat (3) @(negedge clk);
    check_output("rst_load_enable", 32'(load_enable), 32'd0);
    check_output("rst_data_pts", 32'(data_pts), 32'd0);
    check_output("rst_get", 32'(get_tx_packet_data), 32'd0);
    check_output("rst_tx_state", 32'(tx_state), 32'd0);
    check_output("rst_tx_busy", 32'(tx_busy), 32'd0);
    check_output("rst_tx_done", 32'(tx_done), 32'd0);
    check_output("rst_tx_trunc", 32'(tx_trunc), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] ACK");
    apply_stimulus(3'd3, 0, 16'h0000);
    wait_done("done_ack");
    repeat (2) @(negedge clk);

    $display("[TB] DATA0 size 0");
    apply_stimulus(3'd1, 0, 16'h0000);
    wait_done("done_data0_empty");
    repeat (2) @(negedge clk);

    $display("[TB] DATA1 size 3");
    stim_bytes = '{8'h01, 8'h02, 8'h03};
    apply_stimulus(3'd2, 3, 16'h1234);
    wait_done("done_data1_3");
    repeat (2) @(negedge clk);

    $display("[TB] DATA0 size 100 truncated");
    apply_stimulus(3'd1, 100, 16'hA55A);
    wait_done("done_trunc");
    repeat (2) @(negedge clk);

    $display("[TB] reset during payload byte 5");
    apply_stimulus(3'd1, 20, 16'h0F0F);
    data_seen = 0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (load_enable && tx_state == 3'd3) data_seen++;
      if (data_seen == 5) hit = 1'b1;
    end
    if (!hit) fail_event("reach_byte5", "got fewer than 5 payload loads expected 5");
    n_rst = 1'b0;
    tx_packet = 3'd0;
    exp_loads.delete();
    exp_gets.delete();
    pay_q.delete();
    @(negedge clk);
    check_output("abort_load_enable", 32'(load_enable), 32'd0);
    check_output("abort_data_pts", 32'(data_pts), 32'd0);
    check_output("abort_get", 32'(get_tx_packet_data), 32'd0);
    check_output("abort_tx_state", 32'(tx_state), 32'd0);
    check_output("abort_tx_busy", 32'(tx_busy), 32'd0);
    check_output("abort_tx_done", 32'(tx_done), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(3'd4, 0, 16'h0000);
    wait_done("done_nak_after_reset");
    repeat (2) @(negedge clk);

    $display("[TB] tx_packet 6 ignored");
    tx_packet = 3'd6;
    for (int i = 0; i < 12; i++) begin
      force_bc = i[0];
      @(negedge clk);
      check_output("ignore6_busy", 32'(tx_busy), 32'd0);
      check_output("ignore6_load", 32'(load_enable), 32'd0);
    end
    force_bc = 1'b0;
    tx_packet = 3'd0;
    repeat (2) @(negedge clk);

    $display("[TB] DATA0 size 1 with crc_in BEEF");
    apply_stimulus(3'd1, 1, 16'hBEEF);
    wait_done("done_beef");
    repeat (2) @(negedge clk);

    $display("[TB] random packets");
    for (int p = 0; p < 25; p++) begin
      t = 3'($urandom_range(1, 5));
      sz = 0;
      if (t <= 3'd2) sz = ($urandom_range(0, 7) == 0) ? $urandom_range(65, 127) : $urandom_range(0, 20);
      apply_stimulus(t, sz, 16'($urandom));
      wait_done("done_random");
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check_output("final_loads_left", 32'(exp_loads.size()), 32'd0);
    check_output("final_packets_left", 32'(exp_gets.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
